replica_unloader: RTL and testbench
===================================

# replica_unloader

Receive-side counterpart of the replica shift chain. During a shift-out pass it captures the replica words arriving at the chain tail (`out_data[replica_num]`), one per cycle, `city_num` words per replica, for all `replica_num` replicas. It tags each word with its replica and city index, buffers it in a FIFO, and presents it to the host/readout side on a valid/ready stream. The chain cannot stall, so the unloader absorbs the fixed-rate burst and reports any loss.

## Interface
Parameters:
- `CAPTURE_LAT`, default 2: cycles from `start` to the first valid tail word. This covers the command register and the RAM read stage.
- `FIFO_DEPTH`, default 16: buffer entries. Must be a power of 2 and ≥ 2.
- Word counts come from the package constants `city_num` and `replica_num`; they are not parameters.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse, issued in the same cycle the controller drives the shift-out `PREV` command.
- `tail_data` in `replica_data`: chain tail word.
- `busy` out 1: unload pass in progress, capture or drain.
- `done` out 1: one-cycle pulse when the pass completes.
- `overflow` out 1: sticky; a captured word was dropped.
- `m_valid` out 1: output word available.
- `m_ready` in 1: consumer accepts the word.
- `m_data` out `replica_data`: captured word.
- `m_replica` out `replica_idx_t`: replica index of the word.
- `m_city` out `city_idx_t`: word index within the replica, 0..`city_num`-1.
- `m_last` out 1: last word of the whole pass.
- `perm_err` out 1: sticky; present only with the macro enabled.

## Operation
State machine: IDLE → WAIT → CAPT → DRAIN → IDLE.
- **IDLE:** `start` loads the latency counter with `CAPTURE_LAT`-1, clears `overflow` and `perm_err`, and enters WAIT. If `CAPTURE_LAT`==0, it enters CAPT directly.
- **WAIT:** the counter decrements; at 0 the FSM enters CAPT.
- **CAPT:** samples `tail_data` every cycle and pushes {data, replica, city, last}.
  - The city counter wraps at `city_num`-1 and increments the replica counter.
  - After word `replica_num*city_num`-1 the FSM enters DRAIN.
- **DRAIN:** waits for the FIFO to be empty. It then pulses `done` and returns to IDLE.
- **FIFO full on a capture cycle:** the word is dropped, `overflow` is set, and the counters still advance. As a result, indices on later words remain correct.
- **Simultaneous push and pop when full:** the pop frees the slot, so the push succeeds and no overflow is flagged.
- **`start` while `busy`:** ignored.
- **`reset` asserted mid-pass:** the FSM returns to IDLE, the FIFO is emptied, and all outputs take their reset values immediately.
- **Output stream:** `m_valid` stays high until `m_ready`, and `m_*` are stable while `m_valid`&&!`m_ready`.
- **Index arithmetic:** unsigned; counter widths are `$clog2` of the package constants, with a minimum of 1.

## Timing
- Reset values: `busy`=0, `done`=0, `overflow`=0, `perm_err`=0, `m_valid`=0. `m_data`, `m_replica`, `m_city` and `m_last` are all 0.
- `start` at cycle T → the first sample is taken at T+`CAPTURE_LAT`. The last sample is at T+`CAPTURE_LAT`+`replica_num*city_num`-1.
- `busy` is high from T+1 until the cycle `done` pulses, inclusive.
- Push-to-`m_valid` latency is 1 cycle (registered FIFO output). `m_ready` is honoured in the same cycle.
- `done` asserts 1 cycle after the pop that empties the FIFO; it is never earlier than 1 cycle after the last sample.

## Configuration
- `REPLICA_UNLOAD_PERM_CHECK_EN` defined:
  - Per replica, a bitmap of 2^7 entries marks every 7-bit element seen across the replica's `city_num` words.
  - A repeated value sets `perm_err`.
  - The bitmap clears at each replica boundary.
  - `perm_err` is sticky until the next `start`.
- Undefined: the port and the checking logic are absent. The data path is unchanged.

## Structure
- `replica_pkg` gains `replica_idx_t` and `city_idx_t` (index typedefs sized from `replica_num` and `city_num`) and an `unload_state_t` enum. It continues to supply `replica_data`, `city_num` and `replica_num`.
- Sub-module `replica_fifo`: synchronous FIFO, parameterised on depth and element type, with full/empty flags and a registered output. It is reusable for the shift-in feeder.

## Test plan
- **Full pass, no backpressure:** `m_ready`=1, `start` at T → words are seen at T+3..T+2+`replica_num*city_num`. `m_city` runs 0..`city_num`-1 and `m_replica` increments at each wrap. `m_last` is on the final word only. `done` pulses once; `overflow`=0.
- **Backpressure:** `m_ready` is held low for the whole capture with `FIFO_DEPTH`=16 and 32 words → the first 16 words are kept and 16 are dropped, with `overflow`=1. After release, 16 words drain with their original indices, then `done` pulses.
- **Random `m_ready` (50%), deep FIFO:** output order and data match the tail stream exactly; `overflow`=0.
- **`start` during capture and reset mid-capture:**
  - The second `start` is ignored and the word count is unchanged.
  - `reset`=0 at word 5 → `busy`=0 and `m_valid`=0 on the next edge, with no `done` pulse.
- **Macro on, duplicate element:** element value 0x05 is injected twice within replica 1 → `perm_err`=1. The same value appearing in replica 0 and replica 1 → `perm_err`=0.

Source files
------------

// File: rtl/replica_pkg.sv
// Shared types for the replica shift chain: word type, chain dimensions,
// index typedefs and the unloader state encoding.
package replica_pkg;

  localparam int unsigned city_num    = 8;
  localparam int unsigned replica_num = 4;
  localparam int unsigned elem_w      = 7;

  typedef logic [7:0] replica_data;

  localparam int unsigned city_idx_w    = (city_num > 1) ? $clog2(city_num) : 1;
  localparam int unsigned replica_idx_w = (replica_num > 1) ? $clog2(replica_num) : 1;

  typedef logic [city_idx_w-1:0]    city_idx_t;
  typedef logic [replica_idx_w-1:0] replica_idx_t;

  typedef enum logic [1:0] {
    UNLOAD_IDLE  = 2'd0,
    UNLOAD_WAIT  = 2'd1,
    UNLOAD_CAPT  = 2'd2,
    UNLOAD_DRAIN = 2'd3
  } unload_state_t;

  typedef struct packed {
    replica_data  data;
    replica_idx_t replica;
    city_idx_t    city;
    logic         last;
  } unload_word_t;

endpackage

// File: rtl/replica_fifo.sv
// Synchronous FIFO with full/empty flags and a flop-backed read port.
// DEPTH must be a power of 2; a pop frees the slot for a same-cycle push.
module replica_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter type         T     = logic [7:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != FULL_CNT) || do_pop);
    wr_d    = wr_q + PTR_W'(do_push);
    rd_d    = rd_q + PTR_W'(do_pop);
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (PTR_W + 1)'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) begin
        mem_q[wr_q] <= push_data;
      end
    end
  end

  assign pop_data = mem_q[rd_q];
  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);

endmodule

// File: rtl/replica_unloader.sv
// Captures a full shift-out pass from the chain tail, tags each word with its
// replica/city index and streams it out through a FIFO. Optional duplicate-
// element check per replica is enabled by REPLICA_UNLOAD_PERM_CHECK_EN.
module replica_unloader
  import replica_pkg::*;
#(
  parameter int unsigned CAPTURE_LAT = 2,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  replica_data  tail_data,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic         m_valid,
  input  logic         m_ready,
  output replica_data  m_data,
  output replica_idx_t m_replica,
  output city_idx_t    m_city,
  output logic         m_last
`ifdef REPLICA_UNLOAD_PERM_CHECK_EN
  ,
  output logic         perm_err
`endif
);

  localparam int unsigned      LAT_W     = (CAPTURE_LAT > 1) ? $clog2(CAPTURE_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD  = (CAPTURE_LAT > 1) ? LAT_W'(CAPTURE_LAT - 1) : '0;
  localparam replica_idx_t     REP_LAST  = replica_idx_t'(replica_num - 1);
  localparam city_idx_t        CITY_LAST = city_idx_t'(city_num - 1);

  unload_state_t    state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  replica_idx_t     rep_q, rep_d;
  city_idx_t        city_q, city_d;
  logic             overflow_q, overflow_d;
  logic             capt, last_word;
  logic             fifo_full, fifo_empty;
  unload_word_t     push_word, pop_word;

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    rep_d      = rep_q;
    city_d     = city_q;
    overflow_d = overflow_q;
    capt       = (state_q == UNLOAD_CAPT);
    last_word  = (rep_q == REP_LAST) && (city_q == CITY_LAST);
    case (state_q)
      UNLOAD_IDLE: begin
        if (start) begin
          rep_d      = '0;
          city_d     = '0;
          overflow_d = 1'b0;
          lat_d      = LAT_LOAD;
          state_d    = (CAPTURE_LAT > 1) ? UNLOAD_WAIT : UNLOAD_CAPT;
        end
      end
      UNLOAD_WAIT: begin
        // IDLE->WAIT already spent one cycle, so leave when the count reaches 1
        if (lat_q <= LAT_W'(1)) begin
          state_d = UNLOAD_CAPT;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      UNLOAD_CAPT: begin
        if (fifo_full && !m_ready) begin
          overflow_d = 1'b1;
        end
        if (city_q == CITY_LAST) begin
          city_d = '0;
          rep_d  = rep_q + replica_idx_t'(1);
        end else begin
          city_d = city_q + city_idx_t'(1);
        end
        if (last_word) begin
          state_d = UNLOAD_DRAIN;
        end
      end
      UNLOAD_DRAIN: begin
        if (fifo_empty) begin
          state_d = UNLOAD_IDLE;
        end
      end
      default: state_d = UNLOAD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= UNLOAD_IDLE;
      lat_q      <= '0;
      rep_q      <= '0;
      city_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      rep_q      <= rep_d;
      city_q     <= city_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    push_word         = '0;
    push_word.data    = tail_data;
    push_word.replica = rep_q;
    push_word.city    = city_q;
    push_word.last    = last_word;
  end

  replica_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (unload_word_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capt),
    .push_data (push_word),
    .pop       (m_ready),
    .pop_data  (pop_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign busy      = (state_q != UNLOAD_IDLE);
  assign done      = (state_q == UNLOAD_DRAIN) && fifo_empty;
  assign overflow  = overflow_q;
  assign m_valid   = !fifo_empty;
  assign m_data    = pop_word.data;
  assign m_replica = pop_word.replica;
  assign m_city    = pop_word.city;
  assign m_last    = pop_word.last;

`ifdef REPLICA_UNLOAD_PERM_CHECK_EN
  logic [2**elem_w-1:0] seen_q, seen_d;
  logic                 perm_err_q, perm_err_d;
  logic [elem_w-1:0]    elem;

  // Checks the tail stream itself, so dropped words are still covered
  always_comb begin
    seen_d     = seen_q;
    perm_err_d = perm_err_q;
    elem       = tail_data[elem_w-1:0];
    if ((state_q == UNLOAD_IDLE) && start) begin
      seen_d     = '0;
      perm_err_d = 1'b0;
    end else if (capt) begin
      if (seen_q[elem]) begin
        perm_err_d = 1'b1;
      end
      if (city_q == CITY_LAST) begin
        seen_d = '0;
      end else begin
        seen_d[elem] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_q     <= '0;
      perm_err_q <= 1'b0;
    end else begin
      seen_q     <= seen_d;
      perm_err_q <= perm_err_d;
    end
  end

  assign perm_err = perm_err_q;
`endif

endmodule

// File: tb/tb_replica_unloader.sv
// Scoreboard bench for replica_unloader: a shallow (16) and a deep (64)
// instance share start/tail/reset; monitors pop expected words per instance.
`timescale 1ns/1ps
module tb_replica_unloader;
  import replica_pkg::*;

  localparam int N_WORDS = replica_num * city_num;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         m_ready = 1'b1;
  logic         m_ready_deep = 1'b1;
  replica_data  tail_data = '0;

  logic         busy, done, overflow, m_valid, m_last;
  replica_data  m_data;
  replica_idx_t m_replica;
  city_idx_t    m_city;
  logic         busy_deep, done_deep, overflow_deep, m_valid_deep, m_last_deep;
  replica_data  m_data_deep;
  replica_idx_t m_replica_deep;
  city_idx_t    m_city_deep;
`ifdef REPLICA_UNLOAD_PERM_CHECK_EN
  logic         perm_err, perm_err_deep;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int first_valid_cyc = -1;

  unload_word_t exp_q[$];
  unload_word_t exp_deep_q[$];
  replica_data  words [N_WORDS];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  replica_unloader #(.CAPTURE_LAT(2), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .tail_data(tail_data),
    .busy(busy), .done(done), .overflow(overflow), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_replica(m_replica),
    .m_city(m_city), .m_last(m_last)
`ifdef REPLICA_UNLOAD_PERM_CHECK_EN
    , .perm_err(perm_err)
`endif
  );

  replica_unloader #(.CAPTURE_LAT(2), .FIFO_DEPTH(64)) dut_deep (
    .clk(clk), .reset(reset), .start(start), .tail_data(tail_data),
    .busy(busy_deep), .done(done_deep), .overflow(overflow_deep),
    .m_valid(m_valid_deep), .m_ready(m_ready_deep), .m_data(m_data_deep),
    .m_replica(m_replica_deep), .m_city(m_city_deep), .m_last(m_last_deep)
`ifdef REPLICA_UNLOAD_PERM_CHECK_EN
    , .perm_err(perm_err_deep)
`endif
  );

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop on handshake, and require held outputs under backpressure
  unload_word_t cur_m, held_m, e_m;
  logic         hold_m = 1'b0;
  always @(negedge clk) begin
    cur_m = '{data: m_data, replica: m_replica, city: m_city, last: m_last};
    if (done) done_cnt++;
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (hold_m) cmp("main_hold", {17'd0, m_valid, cur_m}, {17'd0, 1'b1, held_m});
    hold_m = m_valid && !m_ready;
    held_m = cur_m;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main_extra got=%0h exp=none", cur_m);
      end else begin
        e_m = exp_q.pop_front();
        cmp("main_word", 32'(cur_m), 32'(e_m));
      end
    end
  end

  unload_word_t cur_d, held_d, e_d;
  logic         hold_d = 1'b0;
  always @(negedge clk) begin
    cur_d = '{data: m_data_deep, replica: m_replica_deep, city: m_city_deep, last: m_last_deep};
    if (hold_d) cmp("deep_hold", {17'd0, m_valid_deep, cur_d}, {17'd0, 1'b1, held_d});
    hold_d = m_valid_deep && !m_ready_deep;
    held_d = cur_d;
    if (m_valid_deep && m_ready_deep) begin
      if (exp_deep_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deep_extra got=%0h exp=none", cur_d);
      end else begin
        e_d = exp_deep_q.pop_front();
        cmp("deep_word", 32'(cur_d), 32'(e_d));
      end
    end
  end

  function automatic void fill_words(input int seed);
    for (int i = 0; i < N_WORDS; i++) begin
      int r = i / city_num;
      int c = i % city_num;
      words[i] = {1'(c ^ seed), 7'((r * 13 + c * 5 + seed) % 128)};
    end
  endfunction

  function automatic unload_word_t mk(input int i);
    unload_word_t w;
    w.data    = words[i];
    w.replica = replica_idx_t'(i / city_num);
    w.city    = city_idx_t'(i % city_num);
    w.last    = (i == N_WORDS - 1);
    return w;
  endfunction

  // One pass: start at cycle T, word i presented in cycle T+2+i
  task automatic run_pass(input string tag, input int keep_n, input bit ready_low,
                          input bit rand_deep, input int restart_at, input int reset_at,
                          input bit exp_ovf);
    int t0, d0, n;
    d0 = done_cnt;
    first_valid_cyc = -1;
    start = 1'b1;
    if (ready_low) m_ready = 1'b0;
    t0 = cyc;
    cmp({tag, "_busy_T"}, 32'(busy), 0);
    tick();
    start = 1'b0;
    cmp({tag, "_busy_T1"}, 32'(busy), 1);
    tick();
    for (int i = 0; i < N_WORDS; i++) begin
      if (i == reset_at) begin
        reset = 1'b0;
        exp_q.delete();
        exp_deep_q.delete();
        tick();
        cmp({tag, "_rst_busy"}, {busy, busy_deep}, 0);
        cmp({tag, "_rst_valid"}, {m_valid, m_valid_deep}, 0);
        cmp({tag, "_rst_ovf"}, 32'(overflow), 0);
        reset = 1'b1;
        tick();
        tick();
        cmp({tag, "_rst_done"}, 32'(done_cnt), 32'(d0));
        cmp({tag, "_rst_idle"}, {busy, m_valid}, 0);
        return;
      end
      tail_data = words[i];
      start = (i == restart_at);
      if (rand_deep) m_ready_deep = 1'($urandom_range(0, 1));
      if (i < keep_n) exp_q.push_back(mk(i));
      exp_deep_q.push_back(mk(i));
      tick();
    end
    start = 1'b0;
    tail_data = replica_data'($urandom);
    if (tag == "full") cmp("full_first_valid", 32'(first_valid_cyc), 32'(t0 + 3));
    cmp({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    cmp({tag, "_ovf_deep"}, 32'(overflow_deep), 0);
    m_ready = 1'b1;
    m_ready_deep = 1'b1;
    n = 0;
    while ((busy || busy_deep) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=busy exp=idle", tag);
    end
    tick();
    cmp({tag, "_done_once"}, 32'(done_cnt - d0), 1);
    cmp({tag, "_left_main"}, 32'(exp_q.size()), 0);
    cmp({tag, "_left_deep"}, 32'(exp_deep_q.size()), 0);
    cmp({tag, "_ovf_sticky"}, 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    #3;
    cmp("reset_ctrl", {busy, done, overflow, m_valid}, 0);
    cmp("reset_data", {m_data, 8'(m_replica), 8'(m_city), 7'd0, m_last}, 0);
`ifdef REPLICA_UNLOAD_PERM_CHECK_EN
    cmp("reset_perm", 32'(perm_err), 0);
`endif
    tick();
    reset = 1'b1;
    tick();

    fill_words(0);
    run_pass("full", N_WORDS, 1'b0, 1'b0, -1, -1, 1'b0);
    fill_words(3);
    run_pass("bp", 16, 1'b1, 1'b0, -1, -1, 1'b1);
    fill_words(7);
    run_pass("rand", N_WORDS, 1'b0, 1'b1, -1, -1, 1'b0);
    fill_words(11);
    run_pass("restart", N_WORDS, 1'b0, 1'b0, 10, -1, 1'b0);
    fill_words(20);
    run_pass("rst", N_WORDS, 1'b0, 1'b0, -1, 5, 1'b0);
    fill_words(0);
    run_pass("after_rst", N_WORDS, 1'b0, 1'b0, -1, -1, 1'b0);

`ifdef REPLICA_UNLOAD_PERM_CHECK_EN
    cmp("perm_clean", 32'(perm_err), 0);
    // Replica 1 (elements 13+5c) gets 0x05 at cities 2 and 6
    fill_words(0);
    words[city_num + 2] = 8'h05;
    words[city_num + 6] = 8'h05;
    run_pass("perm_dup", N_WORDS, 1'b0, 1'b0, -1, -1, 1'b0);
    cmp("perm_dup_err", 32'(perm_err), 1);
    // 0x05 sits at replica 0 city 1 already; one more in replica 1 is legal
    fill_words(0);
    words[city_num + 3] = 8'h05;
    run_pass("perm_cross", N_WORDS, 1'b0, 1'b0, -1, -1, 1'b0);
    cmp("perm_cross_err", 32'(perm_err), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
